// File: rtl/cache_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto a single physical-memory port.
// Round-robin grant on contention; one transfer in flight at a time.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [1:0]            fsm_state
);

    // Handshake: requests are levels held until the matching one-cycle resp;
    // pmem strobes are levels held until the one-cycle pmem_resp.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                state, state_next;
    logic                  last_grant, last_grant_next;
    logic                  op_write, op_write_next;
    logic [ADDR_WIDTH-1:0] addr_q, addr_next;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_next;
    logic [LINE_WIDTH-1:0] i_line_q, d_line_q;
    logic                  i_req, d_req, in_serve;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            op_write   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_line_q   <= '0;
            d_line_q   <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            op_write   <= op_write_next;
            addr_q     <= addr_next;
            wdata_q    <= wdata_next;
            if (i_resp) i_line_q <= pmem_rdata;
            if (d_resp) d_line_q <= pmem_rdata;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        op_write_next   = op_write;
        addr_next       = addr_q;
        wdata_next      = wdata_q;
        case (state)
            IDLE: begin
                // On contention the port that did not win last time goes first.
                if (i_req && (!d_req || last_grant == GRANT_D)) begin
                    state_next      = SERVE_I;
                    last_grant_next = GRANT_I;
                    op_write_next   = 1'b0;
                    addr_next       = i_address;
                    wdata_next      = '0;
                end else if (d_req) begin
                    state_next      = SERVE_D;
                    last_grant_next = GRANT_D;
                    op_write_next   = d_write;
                    addr_next       = d_address;
                    wdata_next      = d_wdata;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_serve     = (state == SERVE_I) || (state == SERVE_D);
    assign pmem_read    = in_serve && !op_write;
    assign pmem_write   = in_serve && op_write;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_resp  = (state == SERVE_I) && pmem_resp;
    assign d_resp  = (state == SERVE_D) && pmem_resp;
    // Returned line is visible in the resp cycle itself, then held.
    assign i_rdata = i_resp ? pmem_rdata : i_line_q;
    assign d_rdata = d_resp ? pmem_rdata : d_line_q;

    assign fsm_state = state;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a pmem responder drives transfers while
// a negedge monitor checks every resp pulse against an expected queue.
module tb_cache_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;
    localparam int W  = LW + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_address = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;
    logic [1:0]    fsm_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: every resp pulse must match the queue head
    always @(negedge clk) begin
        if (i_resp || d_resp) begin
            logic [W-1:0] act;
            act = {i_resp, d_resp, (i_resp ? i_rdata : d_rdata)};
            if (exp_q.size() == 0) begin
                check("unexpected_resp", LW'(act[W-1:W-2]), LW'(0));
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("resp_ports", LW'(act[W-1:W-2]), LW'(e[W-1:W-2]));
                check("resp_rdata", act[LW-1:0], e[LW-1:0]);
            end
        end
    end

    task automatic expect_resp(input logic is_d, input logic [LW-1:0] line);
        exp_q.push_back({~is_d, is_d, line});
    endtask

    // pmem responder: waits for a strobe, holds for n cycles, then pulses pmem_resp
    task automatic serve(input string name, input logic exp_write, input logic [AW-1:0] exp_addr,
                         input logic [LW-1:0] exp_wdata, input int n, input logic [LW-1:0] rdata,
                         input int exp_wait, input logic mutate);
        int waited = 0;
        while (!(pmem_read || pmem_write) && waited < 10) begin
            tick();
            waited++;
        end
        if (!(pmem_read || pmem_write)) begin
            check({name, "_timeout"}, LW'(0), LW'(1));
            return;
        end
        if (exp_wait >= 0) check({name, "_grant_latency"}, LW'(waited), LW'(exp_wait));
        for (int k = 0; k < n; k++) begin
            check({name, "_pmem_read"}, LW'(pmem_read), LW'(!exp_write));
            check({name, "_pmem_write"}, LW'(pmem_write), LW'(exp_write));
            check({name, "_pmem_address"}, LW'(pmem_address), LW'(exp_addr));
            if (exp_write) check({name, "_pmem_wdata"}, pmem_wdata, exp_wdata);
            if (k == 0 && mutate) begin
                d_address = 16'h5000;
                d_wdata   = ~d_wdata;
            end
            if (k == n - 1) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rdata;
            end
            tick();
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
        end
        check({name, "_done_state"}, LW'(fsm_state), LW'(ST_DONE));
        check({name, "_done_no_strobe"}, LW'({pmem_read, pmem_write}), LW'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_state"}, LW'(fsm_state), LW'(ST_IDLE));
        check({name, "_strobes"}, LW'({pmem_read, pmem_write, i_resp, d_resp}), LW'(0));
        check({name, "_pmem_address"}, LW'(pmem_address), LW'(0));
        check({name, "_pmem_wdata"}, pmem_wdata, LW'(0));
        check({name, "_i_rdata"}, i_rdata, LW'(0));
        check({name, "_d_rdata"}, d_rdata, LW'(0));
    endtask

    localparam logic [LW-1:0] LINE_A5 = {16{8'hA5}};
    localparam logic [LW-1:0] LINE_WB = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [LW-1:0] LINE_5A = {16{8'h5A}};
    localparam logic [LW-1:0] LINE_C3 = {16{8'hC3}};

    initial begin
        #1;
        check_reset_outputs("reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_reset");

        // single I read, 3 serve cycles
        i_read = 1'b1;
        i_address = 16'h1230;
        expect_resp(1'b0, LINE_A5);
        serve("i_fill", 1'b0, 16'h1230, '0, 3, LINE_A5, 1, 1'b0);
        i_read = 1'b0;
        tick();
        check("i_fill_idle", LW'(fsm_state), LW'(ST_IDLE));
        check("i_fill_i_rdata", i_rdata, LINE_A5);
        check("i_fill_d_rdata", d_rdata, LW'(0));

        // D writeback with address/data changed mid-transfer
        d_write = 1'b1;
        d_address = 16'h4000;
        d_wdata = LINE_WB;
        expect_resp(1'b1, LINE_5A);
        serve("d_wb", 1'b1, 16'h4000, LINE_WB, 3, LINE_5A, 1, 1'b1);
        d_write = 1'b0;
        tick();
        check("d_wb_d_rdata", d_rdata, LINE_5A);

        // spurious pmem_resp in IDLE
        pmem_resp = 1'b1;
        pmem_rdata = '1;
        repeat (2) begin
            tick();
            check("spurious_state", LW'(fsm_state), LW'(ST_IDLE));
            check("spurious_strobes", LW'({pmem_read, pmem_write}), LW'(0));
        end
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        tick();
        check("spurious_i_rdata", i_rdata, LINE_A5);
        check("spurious_d_rdata", d_rdata, LINE_5A);

        // read+write together is a write; minimum latency of 2
        d_read = 1'b1;
        d_write = 1'b1;
        d_address = 16'h0080;
        d_wdata = LINE_C3;
        expect_resp(1'b1, LINE_A5);
        serve("d_rw", 1'b1, 16'h0080, LINE_C3, 1, LINE_A5, 1, 1'b0);
        d_read = 1'b0;
        d_write = 1'b0;
        tick();

        // reset in the middle of SERVE_D aborts the transfer
        d_read = 1'b1;
        d_address = 16'h6000;
        tick();
        check("abort_serving", LW'(pmem_read), LW'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_in_reset");
        d_read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pmem_resp = 1'b1;
        pmem_rdata = '1;
        tick();
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        check_reset_outputs("abort_after");

        // round robin: both held, order must be D, I, D, I
        i_read = 1'b1;
        i_address = 16'h3000;
        d_read = 1'b1;
        d_address = 16'h2000;
        for (int r = 0; r < 2; r++) begin
            logic [LW-1:0] dl, il;
            dl = LW'(128'h1000 + r);
            il = LW'(128'h2000 + r);
            expect_resp(1'b1, dl);
            serve("rr_d", 1'b0, 16'h2000, '0, 2, dl, -1, 1'b0);
            expect_resp(1'b0, il);
            serve("rr_i", 1'b0, 16'h3000, '0, 1, il, -1, 1'b0);
        end
        i_read = 1'b0;
        d_read = 1'b0;
        repeat (3) tick();
        check("final_idle", LW'(fsm_state), LW'(ST_IDLE));
        check("queue_drained", LW'(exp_q.size()), LW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
